syn_pcm_mem_rdr: RTL and testbench
==================================

# syn_pcm_mem_rdr

Fgyrus-side reader for the PCM transfer memory written by Acortex. On each `pcm_data_rdy` it sweeps the full PCM buffer (addresses 0 to 2^ADDR_W-1) through the memory read port. It captures left/right read data on `pcm_rd_valid` and hands ordered stereo samples to the Fgyrus FFT front-end over a valid/ready stream. It sits between the PCM memory read port and the FFT input stage, and applies credit-based flow control so that no read data is ever dropped.

## Interface
- `DATA_W`, 32, PCM sample width per channel
- `ADDR_W`, 7, PCM buffer address width; frame length is 2^ADDR_W samples
- `RD_DELAY`, 2, fixed memory read latency in cycles from `pcm_rden_o` to `pcm_rd_valid_i`
- `FIFO_DEPTH`, 4, capture FIFO entries; must be ≥ RD_DELAY+2 for full throughput
---
- `clk_ir`, in, 1, clock
- `rst_il`, in, 1, reset: asynchronous, active-low
- `pcm_data_rdy_i`, in, 1, single-cycle pulse from Acortex: the buffer holds a complete frame
- `pcm_rden_o`, out, 1, memory read strobe
- `pcm_addr_o`, out, ADDR_W, memory read address
- `lpcm_rdata_i`, in, DATA_W, left read data
- `rpcm_rdata_i`, in, DATA_W, right read data
- `pcm_rd_valid_i`, in, 1, read data valid
- `smp_valid_o`, out, 1, output sample valid
- `smp_ready_i`, in, 1, downstream ready
- `smp_lchnl_o`, out, DATA_W, left sample
- `smp_rchnl_o`, out, DATA_W, right sample
- `smp_idx_o`, out, ADDR_W, index of the sample within the frame
- `frame_done_o`, out, 1, one-cycle pulse after the last sample handshake
- `busy_o`, out, 1, high whenever FSM is not IDLE
- `ovrn_o`, out, 1, one-cycle pulse when `pcm_data_rdy_i` arrives while busy
- `ovrn_cnt_o`, out, 8, saturating overrun count

## Operation
- FSM states and transitions:
  - IDLE goes to READ on `pcm_data_rdy_i`.
  - READ issues reads. It moves to DRAIN in the cycle after the read at address 2^ADDR_W-1 is issued.
  - DRAIN waits until outstanding reads = 0, the FIFO is empty and the last pop has occurred. It then pulses `frame_done_o` and returns to IDLE.
- Read issue:
  - In READ, `pcm_rden_o`=1 iff `fifo_cnt + outstanding < FIFO_DEPTH`. A same-cycle pop earns no credit.
  - `pcm_addr_o` increments after each issued read and starts at 0 for every frame.
- Outstanding counter: +1 on `pcm_rden_o`, -1 on `pcm_rd_valid_i`; both in the same cycle means no change. A `pcm_rd_valid_i` with outstanding = 0 is ignored and does not write the FIFO.
- Capture: on `pcm_rd_valid_i`, {lpcm, rpcm} is pushed to the FIFO. By construction of the credit check, the FIFO never overflows.
- Output:
  - `smp_valid_o` = FIFO not empty.
  - Pop happens on `smp_valid_o & smp_ready_i`.
  - `smp_idx_o` is a pop counter, cleared on entry to READ.
  - Data and index hold stable while valid=1 and ready=0.
- `pcm_data_rdy_i` in READ, in DRAIN, or in the `frame_done_o` cycle:
  - the frame is not restarted;
  - `ovrn_o` pulses;
  - the counter increments, saturating at 255.

## Timing
- Reset values of all outputs are 0; FSM resets to IDLE, and all counters and the FIFO are cleared. Reset mid-frame abandons the frame with no `frame_done_o`. Read data that arrives after reset release while in IDLE is ignored.
- Cycle sequence with ready held high:
  - `pcm_data_rdy_i` in cycle 0.
  - First `pcm_rden_o` (addr 0) in cycle 1.
  - `pcm_rd_valid_i` in cycle 1+RD_DELAY.
  - `smp_valid_o` in cycle 2+RD_DELAY.
- Throughput: one read and one sample per cycle when `smp_ready_i` is held high and FIFO_DEPTH ≥ RD_DELAY+2.
- Last sample handshake in cycle 2^ADDR_W+RD_DELAY+1, `frame_done_o` in the following cycle, IDLE after that.
- All outputs are registered except `smp_valid_o`, `smp_lchnl_o`, `smp_rchnl_o` and `smp_idx_o`, which are driven directly from FIFO and counter registers.

## Configuration
- `SYN_PCM_RDR_OVRN_CNTR_EN`:
  - Defined: `ovrn_cnt_o` is an 8-bit saturating counter of overruns, cleared only by reset.
  - Undefined: `ovrn_cnt_o` is tied to 0 and no counter flops are generated.
- `ovrn_o` and all other behaviour are identical in both builds.

## Structure
- Shared package `syn_fgyrus_pkg` holds:
  - `pcm_rdr_fsm_t` enum (IDLE, READ, DRAIN);
  - `PCM_RDR_OVRN_CNT_W` = 8.
- Sub-module `syn_pcm_rdr_fifo`:
  - synchronous FIFO, width 2*DATA_W, depth FIFO_DEPTH;
  - push/pop/empty/full and occupancy count outputs.
- Top level holds the FSM, address counter, outstanding counter, index counter and overrun logic.

## Test plan
- Default params, ready held high, memory model returns L=addr, R=~addr after 2 cycles, single `pcm_data_rdy_i`:
  - 128 samples with idx 0..127 and L=idx;
  - `frame_done_o` pulse in cycle 132;
  - 128 consecutive `pcm_rden_o` cycles.
- Ready toggled 1-of-3 cycles: at most 4 (fifo_cnt + outstanding) at any time, no dropped or duplicated samples, data order preserved.
- `pcm_data_rdy_i` pulsed in cycle 50 of a frame: frame completes unchanged, `ovrn_o` pulses once, `ovrn_cnt_o`=1 (0 without the macro).
- 300 overrun pulses: `ovrn_cnt_o` saturates at 255.
- `rst_il` asserted mid-READ at addr 40:
  - all outputs are 0 immediately;
  - no `frame_done_o`;
  - the next `pcm_data_rdy_i` restarts at addr 0 with idx 0.
- Spurious `pcm_rd_valid_i` in IDLE: FIFO stays empty, `smp_valid_o` stays 0.

Source files
------------

// File: rtl/syn_fgyrus_pkg.sv
// Shared Fgyrus-side types and constants used by the PCM memory reader.
package syn_fgyrus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } pcm_rdr_fsm_t;

    localparam int PCM_RDR_OVRN_CNT_W = 8;

endpackage

// File: rtl/syn_pcm_mem_rdr_if.sv
// PCM memory read port plus sample stream; master is the reader, slave is memory/FFT side.
interface syn_pcm_mem_rdr_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
);
    logic              pcm_rden_o;
    logic [ADDR_W-1:0] pcm_addr_o;
    logic [DATA_W-1:0] lpcm_rdata_i;
    logic [DATA_W-1:0] rpcm_rdata_i;
    logic              pcm_rd_valid_i;
    logic              smp_valid_o;
    logic              smp_ready_i;
    logic [DATA_W-1:0] smp_lchnl_o;
    logic [DATA_W-1:0] smp_rchnl_o;
    logic [ADDR_W-1:0] smp_idx_o;

    modport master (
        output pcm_rden_o, pcm_addr_o, smp_valid_o, smp_lchnl_o, smp_rchnl_o, smp_idx_o,
        input  lpcm_rdata_i, rpcm_rdata_i, pcm_rd_valid_i, smp_ready_i
    );

    modport slave (
        input  pcm_rden_o, pcm_addr_o, smp_valid_o, smp_lchnl_o, smp_rchnl_o, smp_idx_o,
        output lpcm_rdata_i, rpcm_rdata_i, pcm_rd_valid_i, smp_ready_i
    );
endinterface

// File: rtl/syn_pcm_rdr_fifo.sv
// Show-ahead capture FIFO for stereo read data; head entry is visible on rd_data.
module syn_pcm_rdr_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_ir,
    input  logic             rst_il,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (cnt_reg == '0);
    assign full    = (cnt_reg == CNT_W'(DEPTH));
    assign count   = cnt_reg;
    assign rd_data = mem_reg[rd_ptr_reg];

    // Entries are reset so the sample outputs read zero straight out of reset.
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= wr_data;
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end
endmodule

// File: rtl/syn_pcm_mem_rdr.sv
// Sweeps the PCM buffer once per pcm_data_rdy_i and streams stereo samples under credit flow control.
// Optional SYN_PCM_RDR_OVRN_CNTR_EN adds a saturating overrun counter on ovrn_cnt_o.
module syn_pcm_mem_rdr
    import syn_fgyrus_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 7,
    parameter int RD_DELAY   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_ir,
    input  logic                          rst_il,
    input  logic                          pcm_data_rdy_i,
    syn_pcm_mem_rdr_if.master             bus,
    output logic                          frame_done_o,
    output logic                          busy_o,
    output logic                          ovrn_o,
    output logic [PCM_RDR_OVRN_CNT_W-1:0] ovrn_cnt_o
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W = $clog2(FIFO_DEPTH + RD_DELAY + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    pcm_rdr_fsm_t      state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [OUT_W-1:0]  out_reg, out_next;
    logic [CNT_W-1:0]  fifo_cnt, cnt_next;
    logic              rden_reg, rden_next;
    logic              done_reg, done_next;
    logic              busy_reg;
    logic              ovrn_reg;
    logic              ovrn_event;
    logic              capture, fifo_push, pop;
    logic              fifo_empty, fifo_full;
    logic [2*DATA_W-1:0] fifo_dout;

    // Read data with nothing outstanding is stray and never enters the FIFO.
    assign capture    = bus.pcm_rd_valid_i && (out_reg != '0);
    assign fifo_push  = capture && !fifo_full;
    assign pop        = !fifo_empty && bus.smp_ready_i;
    assign ovrn_event = pcm_data_rdy_i && (state_reg != IDLE);

    syn_pcm_rdr_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_ir  (clk_ir),
        .rst_il  (rst_il),
        .push    (fifo_push),
        .pop     (pop),
        .wr_data ({bus.lpcm_rdata_i, bus.rpcm_rdata_i}),
        .rd_data (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_cnt)
    );

    // rden is registered, so the credit check looks at next-cycle occupancy.
    always_comb begin
        out_next = out_reg;
        if (rden_reg && !capture) begin
            out_next = out_reg + 1'b1;
        end else if (!rden_reg && capture) begin
            out_next = out_reg - 1'b1;
        end
        cnt_next = fifo_cnt;
        if (fifo_push && !pop) begin
            cnt_next = fifo_cnt + 1'b1;
        end else if (!fifo_push && pop) begin
            cnt_next = fifo_cnt - 1'b1;
        end
        state_next = state_reg;
        done_next  = 1'b0;
        unique case (state_reg)
            IDLE:  if (pcm_data_rdy_i) state_next = READ;
            READ:  if (rden_reg && addr_reg == LAST_ADDR) state_next = DRAIN;
            DRAIN: begin
                if (done_reg) begin
                    state_next = IDLE;
                end else begin
                    done_next = (out_next == '0) && (cnt_next == '0);
                end
            end
            default: state_next = IDLE;
        endcase
        rden_next = (state_next == READ) && ((int'(cnt_next) + int'(out_next)) < FIFO_DEPTH);
    end

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            idx_reg   <= '0;
            out_reg   <= '0;
            rden_reg  <= 1'b0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            ovrn_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            out_reg   <= out_next;
            rden_reg  <= rden_next;
            done_reg  <= done_next;
            busy_reg  <= (state_next != IDLE);
            ovrn_reg  <= ovrn_event;
            if (state_reg == IDLE && state_next == READ) begin
                addr_reg <= '0;
                idx_reg  <= '0;
            end else begin
                if (rden_reg) addr_reg <= addr_reg + 1'b1;
                if (pop)      idx_reg  <= idx_reg + 1'b1;
            end
        end
    end

`ifdef SYN_PCM_RDR_OVRN_CNTR_EN
    logic [PCM_RDR_OVRN_CNT_W-1:0] ovrn_cnt_reg;

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            ovrn_cnt_reg <= '0;
        end else if (ovrn_event && ovrn_cnt_reg != '1) begin
            ovrn_cnt_reg <= ovrn_cnt_reg + 1'b1;
        end
    end

    assign ovrn_cnt_o = ovrn_cnt_reg;
`else
    assign ovrn_cnt_o = '0;
`endif

    assign bus.pcm_rden_o  = rden_reg;
    assign bus.pcm_addr_o  = addr_reg;
    assign bus.smp_valid_o = !fifo_empty;
    assign bus.smp_lchnl_o = fifo_dout[2*DATA_W-1:DATA_W];
    assign bus.smp_rchnl_o = fifo_dout[DATA_W-1:0];
    assign bus.smp_idx_o   = idx_reg;
    assign frame_done_o    = done_reg;
    assign busy_o          = busy_reg;
    assign ovrn_o          = ovrn_reg;
endmodule

// File: tb/tb_syn_pcm_mem_rdr.sv
// Bench for syn_pcm_mem_rdr: frame scenario table, fixed-latency memory model and sample scoreboard.
module tb_syn_pcm_mem_rdr;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 7;
    localparam int RD_DELAY   = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int NSMP       = 1 << ADDR_W;

    typedef struct {
        int mode;        // 0 ready high, 1 ready 1-of-3, 2 random, 3 stalled until cycle 320
        int ovrn_first;  // first cycle of extra pcm_data_rdy_i pulses
        int ovrn_num;    // number of extra pulses (= expected ovrn_o pulses)
        int exp_done;    // expected frame_done_o cycle, -1 when timing depends on ready
    } scen_t;

    logic       clk_ir = 1'b0;
    logic       rst_il = 1'b1;
    logic       pcm_data_rdy_i = 1'b0;
    logic       frame_done_o, busy_o, ovrn_o;
    logic [7:0] ovrn_cnt_o;

    syn_pcm_mem_rdr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    syn_pcm_mem_rdr #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_DELAY(RD_DELAY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_ir         (clk_ir),
        .rst_il         (rst_il),
        .pcm_data_rdy_i (pcm_data_rdy_i),
        .bus            (bus),
        .frame_done_o   (frame_done_o),
        .busy_o         (busy_o),
        .ovrn_o         (ovrn_o),
        .ovrn_cnt_o     (ovrn_cnt_o)
    );

    always #5 clk_ir = ~clk_ir;

    int              errors = 0;
    int              checks = 0;
    int              gc = 0;
    int              ovrn_total = 0;
    logic [DATA_W-1:0] base = '0;
    bit              sched_v [8];
    logic [ADDR_W-1:0] sched_a [8];
    scen_t           tbl [6];

    task automatic chk(input bit ok, input string name, input string act, input string req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s, required %s", name, act, req);
        end
    endtask

    task automatic chk_int(input string name, input longint act, input longint req);
        chk(act == req, name, $sformatf("%0d", act), $sformatf("%0d", req));
    endtask

    function automatic int exp_ovrn_cnt();
`ifdef SYN_PCM_RDR_OVRN_CNTR_EN
        return (ovrn_total > 255) ? 255 : ovrn_total;
`else
        return 0;
`endif
    endfunction

    // Memory model: a read seen in cycle c answers in cycle c+RD_DELAY with L=base+addr, R=~L.
    task automatic drive_mem(input bit force_v);
        int slot;
        slot = gc % 8;
        bus.pcm_rd_valid_i = sched_v[slot] || force_v;
        if (sched_v[slot]) begin
            bus.lpcm_rdata_i = base + DATA_W'(sched_a[slot]);
            bus.rpcm_rdata_i = ~(base + DATA_W'(sched_a[slot]));
        end else begin
            bus.lpcm_rdata_i = $urandom;
            bus.rpcm_rdata_i = $urandom;
        end
        sched_v[slot] = 1'b0;
        if (bus.pcm_rden_o) begin
            sched_v[(gc + RD_DELAY) % 8] = 1'b1;
            sched_a[(gc + RD_DELAY) % 8] = bus.pcm_addr_o;
        end
        gc++;
    endtask

    task automatic check_zero(input string name);
        chk_int({name, "_rden"}, bus.pcm_rden_o, 0);
        chk_int({name, "_addr"}, bus.pcm_addr_o, 0);
        chk_int({name, "_smp_valid"}, bus.smp_valid_o, 0);
        chk_int({name, "_lchnl"}, bus.smp_lchnl_o, 0);
        chk_int({name, "_rchnl"}, bus.smp_rchnl_o, 0);
        chk_int({name, "_idx"}, bus.smp_idx_o, 0);
        chk_int({name, "_frame_done"}, frame_done_o, 0);
        chk_int({name, "_busy"}, busy_o, 0);
        chk_int({name, "_ovrn"}, ovrn_o, 0);
        chk_int({name, "_ovrn_cnt"}, ovrn_cnt_o, 0);
    endtask

    task automatic idle_cycles(input int n, input bit force_v, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_ir);
            chk(!bus.smp_valid_o && !frame_done_o && !busy_o, name,
                $sformatf("valid=%0b done=%0b busy=%0b", bus.smp_valid_o, frame_done_o, busy_o),
                "all 0");
            pcm_data_rdy_i   = 1'b0;
            bus.smp_ready_i  = 1'($urandom_range(0, 1));
            drive_mem(force_v);
        end
    endtask

    task automatic run_frame(input int k, input scen_t s);
        int c, nsmp, ndone, done_c, last_pop, nrden, first_rden, last_rden;
        int first_valid, novr, issued, popped, max_infl;
        bit addr_ok, finished;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_l;
        c = 0; nsmp = 0; ndone = 0; done_c = -1; last_pop = -1; nrden = 0;
        first_rden = -1; last_rden = -1; first_valid = -1; novr = 0;
        issued = 0; popped = 0; max_infl = 0; addr_ok = 1'b1; finished = 1'b0;
        exp_addr = '0;
        base = $urandom;
        while (!finished) begin
            @(negedge clk_ir);
            if (bus.pcm_rden_o) begin
                if (bus.pcm_addr_o != exp_addr) addr_ok = 1'b0;
                exp_addr = exp_addr + 1'b1;
                nrden++;
                issued++;
                if (first_rden < 0) first_rden = c;
                last_rden = c;
            end
            if (issued - popped > max_infl) max_infl = issued - popped;
            if (bus.smp_valid_o && first_valid < 0) first_valid = c;
            if (frame_done_o) begin
                ndone++;
                if (done_c < 0) done_c = c;
            end
            if (ovrn_o) novr++;
            if (c == 1) chk_int("busy_after_start", busy_o, 1);
            if (done_c >= 0 && c == done_c + 1) chk_int("busy_after_done", busy_o, 0);

            pcm_data_rdy_i = (c == 0) || (c >= s.ovrn_first && c < s.ovrn_first + s.ovrn_num);
            case (s.mode)
                0:       bus.smp_ready_i = 1'b1;
                1:       bus.smp_ready_i = (c % 3 == 0);
                2:       bus.smp_ready_i = 1'($urandom_range(0, 1));
                default: bus.smp_ready_i = (c >= 320);
            endcase
            drive_mem(1'b0);

            if (bus.smp_valid_o && bus.smp_ready_i) begin
                exp_l = base + DATA_W'(nsmp);
                chk(bus.smp_idx_o == ADDR_W'(nsmp) && bus.smp_lchnl_o == exp_l
                        && bus.smp_rchnl_o == ~exp_l, "sample",
                    $sformatf("idx=%0d L=%h R=%h", bus.smp_idx_o, bus.smp_lchnl_o, bus.smp_rchnl_o),
                    $sformatf("idx=%0d L=%h R=%h", nsmp % NSMP, exp_l, ~exp_l));
                nsmp++;
                popped++;
                last_pop = c;
            end
            c++;
            if (done_c >= 0 && c > done_c + 2) finished = 1'b1;
            if (c >= 3000) finished = 1'b1;
        end
        ovrn_total += s.ovrn_num;

        chk_int("frame_done_count", ndone, 1);
        chk_int("sample_count", nsmp, NSMP);
        chk_int("done_after_last_pop", done_c, last_pop + 1);
        chk_int("read_count", nrden, NSMP);
        chk_int("read_addr_order", addr_ok, 1);
        chk(max_infl <= FIFO_DEPTH, "credit_bound", $sformatf("%0d", max_infl),
            $sformatf("<=%0d", FIFO_DEPTH));
        chk_int("ovrn_pulses", novr, s.ovrn_num);
        chk_int("ovrn_cnt", ovrn_cnt_o, exp_ovrn_cnt());
        if (s.exp_done >= 0) begin
            chk_int("frame_done_cycle", done_c, s.exp_done);
            chk_int("first_rden_cycle", first_rden, 1);
            chk_int("last_rden_cycle", last_rden, NSMP);
            chk_int("first_valid_cycle", first_valid, 2 + RD_DELAY);
        end
        $display("frame %0d mode=%0d samples=%0d reads=%0d done@%0d max_inflight=%0d ovrn=%0d ovrn_cnt=%0d",
                 k, s.mode, nsmp, nrden, done_c, max_infl, novr, ovrn_cnt_o);
    endtask

    task automatic reset_mid_frame();
        int  c;
        bit  hit, stop;
        c = 0;
        stop = 1'b0;
        base = $urandom;
        while (!stop && c < 500) begin
            @(negedge clk_ir);
            hit = bus.pcm_rden_o && (bus.pcm_addr_o == ADDR_W'(40));
            pcm_data_rdy_i  = (c == 0);
            bus.smp_ready_i = 1'b1;
            drive_mem(1'b0);
            c++;
            if (hit) stop = 1'b1;
        end
        chk_int("reached_addr_40", stop, 1);
        #2 rst_il = 1'b0;
        #1 check_zero("reset_mid_read");
        @(negedge clk_ir);
        pcm_data_rdy_i = 1'b0;
        rst_il = 1'b1;
        $display("reset asserted mid-READ at addr 40 after %0d cycles", c);
    endtask

    initial begin
        tbl[0] = '{0, 0, 0, 132};
        tbl[1] = '{0, 50, 1, 132};
        tbl[2] = '{1, 0, 0, -1};
        tbl[3] = '{2, 0, 0, -1};
        tbl[4] = '{3, 1, 300, -1};
        tbl[5] = '{2, 20, 3, -1};
        for (int i = 0; i < 8; i++) begin
            sched_v[i] = 1'b0;
            sched_a[i] = '0;
        end
        bus.smp_ready_i    = 1'b0;
        bus.pcm_rd_valid_i = 1'b0;
        bus.lpcm_rdata_i   = '0;
        bus.rpcm_rdata_i   = '0;

        #1 rst_il = 1'b0;
        repeat (3) @(negedge clk_ir);
        check_zero("reset_state");
        rst_il = 1'b1;

        idle_cycles(3, 1'b0, "idle_quiet");
        idle_cycles(4, 1'b1, "spurious_valid_idle");

        for (int k = 0; k < 6; k++) begin
            run_frame(k, tbl[k]);
        end

        reset_mid_frame();
        ovrn_total = 0;
        idle_cycles(6, 1'b0, "post_reset_idle");
        run_frame(6, tbl[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
